// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: RISC-V size codes,
// FSM state encoding, and the byte-lane helpers used by the LSU.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte-enable for a store of the given size at byte offset off.
  // Lane 0 is the least significant byte of the word.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicates right-justified store data into every lane it could land in,
  // so the byte-enable alone decides which lanes change.
  function automatic logic [31:0] store_align(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] data;
    data = wdata;
    case (funct3)
      F3_B, F3_BU: data = {4{wdata[7:0]}};
      F3_H, F3_HU: data = {2{wdata[15:0]}};
      default:     data = wdata;
    endcase
    return data;
  endfunction

  // Selects the addressed lane(s) of a memory word and sign/zero extends.
  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = 32'd0;
    case (funct3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_W:    res = word;
      F3_BU:   res = {24'd0, sh[7:0]};
      F3_HU:   res = {16'd0, sh[15:0]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word RAM: synchronous write, synchronous read.
// With INIT_ZERO set the contents are cleared by reset; otherwise reset
// leaves the storage untouched so committed stores survive it.
module dmem_array #(
  parameter int AW        = 10,
  parameter int INIT_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  input  logic          re,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  generate
    if (INIT_ZERO != 0) begin : g_clear
      // Write port with reset-time clearing of the whole array
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
          end
        end else if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end else begin : g_keep
      logic unused_rst;
      assign unused_rst = rst;

      // Write port; only the enabled byte lanes change
      always_ff @(posedge clk) begin
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  endgenerate

  // Registered read port, updated only when a read is requested
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the data memory array. Accepts one request
// at a time over valid/ready, commits stores on the accept edge, waits
// WAIT_CYCLES, then pulses rsp_valid for one cycle with extended load data.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_ZERO   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         WORD_AW   = ADDR_W - 2;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           off_q, off_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [WORD_AW-1:0]   word_q, word_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 accept;
  logic                 req_illegal;
  logic                 req_misalign;
  logic                 req_range;
  logic                 req_fault;
  logic                 arr_we;
  logic [3:0]           arr_be;
  logic [31:0]          arr_wdata;
  logic                 arr_re;
  logic [WORD_AW-1:0]   arr_raddr;
  logic [31:0]          arr_rdata;
  logic [31:0]          resp_data;

  // Decode the incoming request: fault classification and store lanes
  always_comb begin
    accept       = req_valid && (state_q == S_IDLE);
    req_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    req_misalign = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: req_misalign = req_addr[0];
      F3_W:        req_misalign = (req_addr[1:0] != 2'b00);
      default:     req_misalign = 1'b0;
    endcase
    req_range = (req_addr >> ADDR_W) != 32'd0;
    req_fault = req_illegal || req_misalign || req_range;
    arr_we    = accept && req_we && !req_fault;
    arr_be    = be_gen(req_funct3, req_addr[1:0]);
    arr_wdata = store_align(req_funct3, req_wdata);
  end

  // Next-state logic: capture on accept, count wait states, one response cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = we_q;
    err_d   = err_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d   = req_funct3;
          off_d  = req_addr[1:0];
          we_d   = req_we;
          err_d  = req_fault;
          word_d = req_addr[ADDR_W-1:2];
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Read the word on the edge that enters RESP so it sees every prior store
    arr_re    = (state_d == S_RESP) && (state_q != S_RESP);
    arr_raddr = (state_q == S_IDLE) ? req_addr[ADDR_W-1:2] : word_q;
  end

  // Response data is live during RESP and held afterwards
  always_comb begin
    resp_data   = (err_q || we_q) ? 32'd0 : load_ext(f3_q, off_q, arr_rdata);
    rsp_rdata_d = (state_q == S_RESP) ? resp_data : rsp_rdata_q;
    rsp_err_d   = (state_q == S_RESP) ? err_q : rsp_err_q;
  end

  // State, captured request fields and held response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      word_q      <= '0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      we_q        <= we_d;
      err_q       <= err_d;
      word_q      <= word_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_d;
  assign rsp_err   = rsp_err_d;

  dmem_array #(
    .AW       (WORD_AW),
    .INIT_ZERO(INIT_ZERO)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .be   (arr_be),
    .waddr(req_addr[ADDR_W-1:2]),
    .wdata(arr_wdata),
    .raddr(arr_raddr),
    .re   (arr_re),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu. Two instances share clock and reset:
// unit 0 has no wait states and a reset-cleared array, unit 1 has three
// wait states and an array that keeps its contents across reset.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0, we0, rdy0, rv0, er0;
  logic [2:0]  f30;
  logic [31:0] a0, wd0, rd0;
  logic        v1, we1, rdy1, rv1, er1;
  logic [2:0]  f31;
  logic [31:0] a1, wd1, rd1;

  int checks   = 0;
  int failures = 0;

  // Byte-level reference memory, one per unit
  logic [7:0] mdl [2][4096];

  dmem_lsu #(.ADDR_W(12), .WAIT_CYCLES(0), .INIT_ZERO(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_funct3(f30), .req_addr(a0), .req_wdata(wd0),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0));

  dmem_lsu #(.ADDR_W(12), .WAIT_CYCLES(3), .INIT_ZERO(0)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_funct3(f31), .req_addr(a1), .req_wdata(wd1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));

  function automatic logic get_ready(input int u);
    return (u == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic get_valid(input int u);
    return (u == 0) ? rv0 : rv1;
  endfunction
  function automatic logic [31:0] get_rdata(input int u);
    return (u == 0) ? rd0 : rd1;
  endfunction
  function automatic logic get_err(input int u);
    return (u == 0) ? er0 : er1;
  endfunction

  task automatic drive(input int u, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (u == 0) begin
      v0 = v; we0 = we; f30 = f3; a0 = a; wd0 = wd;
    end else begin
      v1 = v; we1 = we; f31 = f3; a1 = a; wd1 = wd;
    end
  endtask

  // Reference model: access size, fault rule, store and load semantics
  function automatic int msize(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic mfault(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (a >= 32'h1000) return 1'b1;
    if ((a % msize(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mstore(input int u, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    if (!mfault(f3, a)) begin
      for (int i = 0; i < msize(f3); i++) mdl[u][int'(a) + i] = wd[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] mload(input int u, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    if (mfault(f3, a)) return 32'd0;
    v = 32'd0;
    for (int i = 0; i < msize(f3); i++) v[8*i +: 8] = mdl[u][int'(a) + i];
    if (!f3[2] && msize(f3) == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && msize(f3) == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic mclear0();
    for (int i = 0; i < 4096; i++) mdl[0][i] = 8'h00;
  endtask

  // One complete request: wait for ready, accept, collect the response,
  // then count how long req_ready stays low after the accept edge.
  task automatic access(input int u, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int low, output bit ok);
    int n;
    ok = 0; rd = 32'd0; er = 1'b0; lat = 0; low = 0;
    @(negedge clk);
    drive(u, 1'b1, we, f3, a, wd);
    n = 0;
    while (!get_ready(u) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!get_ready(u)) begin
      drive(u, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      return;
    end
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(u, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      if (!get_ready(u)) low++;
      if (get_valid(u)) begin
        rd  = get_rdata(u);
        er  = get_err(u);
        lat = n;
        break;
      end
    end
    if (lat == 0) return;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (get_ready(u)) begin
        ok = 1;
        break;
      end
      low++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("[TB] FAIL reset ready0: got %b expected 1", rdy0); end
    checks++; if (rv0 !== 1'b0) begin failures++; $display("[TB] FAIL reset valid0: got %b expected 0", rv0); end
    checks++; if (rd0 !== 32'd0) begin failures++; $display("[TB] FAIL reset rdata0: got %h expected 0", rd0); end
    checks++; if (er0 !== 1'b0) begin failures++; $display("[TB] FAIL reset err0: got %b expected 0", er0); end
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("[TB] FAIL reset ready1: got %b expected 1", rdy1); end
    checks++; if (rv1 !== 1'b0) begin failures++; $display("[TB] FAIL reset valid1: got %b expected 0", rv1); end
    checks++; if (rd1 !== 32'd0) begin failures++; $display("[TB] FAIL reset rdata1: got %h expected 0", rd1); end
    @(negedge clk);
    rst = 1'b0;
    mclear0();
  endtask

  task automatic test_sw_loads();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010};
    logic [31:0] adrs [5] = '{32'h11, 32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h8081_7F01};
    logic [31:0] rd; logic er; int lat, low; bit ok;
    access(0, 1'b1, 3'b010, 32'h10, 32'h8081_7F01, rd, er, lat, low, ok);
    mstore(0, 3'b010, 32'h10, 32'h8081_7F01);
    checks++; if (!ok || lat != 1 || low != 1) begin failures++; $display("[TB] FAIL sw timing: got lat=%0d low=%0d ok=%0d expected lat=1 low=1 ok=1", lat, low, ok); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("[TB] FAIL sw response: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    for (int i = 0; i < 5; i++) begin
      access(0, 1'b0, f3s[i], adrs[i], 32'd0, rd, er, lat, low, ok);
      checks++; if (!ok || lat != 1) begin failures++; $display("[TB] FAIL load%0d latency: got %0d expected 1", i, lat); end
      checks++; if (rd !== exps[i] || er !== 1'b0) begin failures++; $display("[TB] FAIL load%0d data: got %h err=%b expected %h err=0", i, rd, er, exps[i]); end
    end
  endtask

  task automatic test_partial_stores();
    logic [31:0] rd; logic er; int lat, low; bit ok;
    access(0, 1'b1, 3'b010, 32'h20, 32'hFFFF_FFFF, rd, er, lat, low, ok);
    access(0, 1'b1, 3'b000, 32'h22, 32'h0000_00AB, rd, er, lat, low, ok);
    access(0, 1'b1, 3'b001, 32'h20, 32'h0000_1234, rd, er, lat, low, ok);
    mstore(0, 3'b010, 32'h20, 32'hFFFF_FFFF);
    mstore(0, 3'b000, 32'h22, 32'h0000_00AB);
    mstore(0, 3'b001, 32'h20, 32'h0000_1234);
    access(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, low, ok);
    checks++; if (!ok || rd !== 32'hFFAB_1234 || er !== 1'b0) begin failures++; $display("[TB] FAIL partial lw: got %h err=%b expected ffab1234 err=0", rd, er); end
  endtask

  task automatic test_faults();
    logic        wes  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s  [6] = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b000, 3'b101};
    logic [31:0] adrs [6] = '{32'h21, 32'h22, 32'h20, 32'h1000, 32'h1003, 32'h23};
    logic [31:0] rd; logic er; int lat, low; bit ok;
    for (int i = 0; i < 6; i++) begin
      access(0, wes[i], f3s[i], adrs[i], 32'd0, rd, er, lat, low, ok);
      checks++; if (!ok || er !== 1'b1 || rd !== 32'd0) begin failures++; $display("[TB] FAIL fault%0d: got err=%b rdata=%h expected err=1 rdata=0", i, er, rd); end
    end
    access(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, low, ok);
    checks++; if (!ok || rd !== 32'hFFAB_1234 || er !== 1'b0) begin failures++; $display("[TB] FAIL fault no-write: got %h err=%b expected ffab1234 err=0", rd, er); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, d; logic er; int lat, low; bit ok;
    d = $urandom;
    access(1, 1'b1, 3'b010, 32'h40, d, rd, er, lat, low, ok);
    mstore(1, 3'b010, 32'h40, d);
    checks++; if (!ok || lat != 4) begin failures++; $display("[TB] FAIL wait latency: got %0d expected 4", lat); end
    checks++; if (low != 4) begin failures++; $display("[TB] FAIL wait ready-low: got %0d expected 4", low); end
    access(1, 1'b0, 3'b001, 32'h42, 32'd0, rd, er, lat, low, ok);
    checks++; if (!ok || lat != 4 || rd !== mload(1, 3'b001, 32'h42) || er !== 1'b0) begin
      failures++; $display("[TB] FAIL wait lh: got %h lat=%0d expected %h lat=4", rd, lat, mload(1, 3'b001, 32'h42));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, rd_b;
    int n, rsp_a, rsp_b;
    bit rdy5;
    d = $urandom; rsp_a = 0; rsp_b = 0; rd_b = 32'd0; rdy5 = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h44, d);
    n = 0;
    while (!rdy1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) drive(1, 1'b1, 1'b0, 3'b010, 32'h44, 32'd0);
      if (k == 5) rdy5 = rdy1;
      if (k == 6) drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      if (rv1 && rsp_a == 0) rsp_a = k;
      else if (rv1 && rsp_b == 0) begin rsp_b = k; rd_b = rd1; end
    end
    mstore(1, 3'b010, 32'h44, d);
    checks++; if (rsp_a != 4) begin failures++; $display("[TB] FAIL b2b first rsp: got cycle %0d expected 4", rsp_a); end
    checks++; if (rdy5 !== 1'b1) begin failures++; $display("[TB] FAIL b2b idle ready: got %b expected 1", rdy5); end
    checks++; if (rsp_b != 9) begin failures++; $display("[TB] FAIL b2b second rsp: got cycle %0d expected 9", rsp_b); end
    checks++; if (rd_b !== d) begin failures++; $display("[TB] FAIL b2b load data: got %h expected %h", rd_b, d); end
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd; logic er; int lat, low; bit ok;
    int n, seen;
    seen = 0;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h30, 32'h5555_AAAA);
    n = 0;
    while (!rdy1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      if (rv1) seen++;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("[TB] FAIL rst-wait ready: got %b expected 1", rdy1); end
        rst = 1'b0;
      end
    end
    mstore(1, 3'b010, 32'h30, 32'h5555_AAAA);
    mclear0();
    checks++; if (seen != 0) begin failures++; $display("[TB] FAIL rst-wait rsp: got %0d pulses expected 0", seen); end
    access(1, 1'b0, 3'b010, 32'h30, 32'd0, rd, er, lat, low, ok);
    checks++; if (!ok || rd !== 32'h5555_AAAA || er !== 1'b0) begin failures++; $display("[TB] FAIL rst-wait kept store: got %h err=%b expected 5555aaaa err=0", rd, er); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; logic er, we, exp_er; logic [2:0] f3;
    int lat, low; bit ok;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      wd = $urandom;
      exp_er = mfault(f3, a);
      exp_rd = we ? 32'd0 : mload(0, f3, a);
      access(0, we, f3, a, wd, rd, er, lat, low, ok);
      if (we) mstore(0, f3, a, wd);
      checks++; if (!ok || lat != 1) begin failures++; $display("[TB] FAIL rand%0d latency: got %0d expected 1", i, lat); end
      checks++; if (er !== exp_er) begin failures++; $display("[TB] FAIL rand%0d err: got %b expected %b (we=%b f3=%0d a=%h)", i, er, exp_er, we, f3, a); end
      checks++; if (rd !== exp_rd) begin failures++; $display("[TB] FAIL rand%0d rdata: got %h expected %h (we=%b f3=%0d a=%h)", i, rd, exp_rd, we, f3, a); end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4096; i++) mdl[1][i] = 8'hxx;
    mclear0();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sw_loads();
    test_reset();
    test_partial_stores();
    test_faults();
    test_wait_states();
    test_back_to_back();
    test_reset_during_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the single-cycle word data memory.
- Byte-addressed, word-organised RAM with RISC-V load/store sizing (SB/SH/SW, LB/LH/LW/LBU/LHU) and sign/zero extension.
- Valid/ready request handshake, configurable wait states and a one-cycle response pulse.
- Flags misaligned or out-of-range accesses.
- Sits between the datapath MEM stage and the storage array.

Parameters:
- ADDR_W, 12, byte-address width; array holds 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 0, extra latency cycles between request accept and response (0..15).
- INIT_ZERO, 0, 1 = array cleared by reset (simulation/FPGA only); 0 = contents undefined at power-up.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access fault (misaligned, out of range, illegal funct3); valid with rsp_valid.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Array cleared only if INIT_ZERO = 1.
- Accept: a request is accepted on the rising edge where req_valid && req_ready. Request fields are registered on that edge.
- States:
  - IDLE: req_ready = 1. On accept, go to WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: req_ready = 0; counter counts WAIT_CYCLES-1 down to 0, then go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, req_ready = 0, then return to IDLE. No back-to-back accept, so throughput is one access per WAIT_CYCLES+2 cycles.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
- Fault checks, evaluated on the accepting edge:
  - H/HU misaligned if addr[0] = 1.
  - W misaligned if addr[1:0] != 0.
  - Out of range if addr[31:ADDR_W] != 0.
  - Illegal if funct3 is 011, 110 or 111.
  - Any fault: no array write, rsp_err = 1, rsp_rdata = 0.
- Stores:
  - Commit to the array on the accepting edge.
  - Byte-enables are derived from size and addr[1:0]: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all lanes.
  - Unselected bytes are unchanged.
  - Store response: rsp_rdata = 0, rsp_err = 0.
- Loads:
  - The word is read from the array on the edge entering RESP, so it reflects all previously committed stores.
  - Lane select uses addr[1:0].
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- Outside RESP, rsp_rdata and rsp_err hold their last values; only rsp_valid qualifies them.
- req_* inputs are ignored while req_ready = 0.
- Reset mid-operation:
  - The pending response is discarded and the FSM returns to IDLE.
  - A store already committed on its accept edge stays committed.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM state encoding S_IDLE, S_WAIT, S_RESP;
  - function be_gen(funct3, addr[1:0]) returning a 4-bit byte-enable;
  - function load_ext(funct3, addr[1:0], word) returning the 32-bit extended result.
- One sub-module: dmem_array. It is a byte-enabled synchronous-write, synchronous-read RAM, parameterised by word-address width, with ports clk, we, be[3:0], waddr, wdata, raddr, re, rdata.

Test Plan:
- Reset then idle: assert rst mid-cycle -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0 immediately, without waiting for a clock edge.
- SW then loads, WAIT_CYCLES = 0:
  - SW addr 0x10, data 0x8081_7F01.
  - LB 0x11 -> 0x0000_007F. LB 0x13 -> 0xFFFF_FF80. LBU 0x13 -> 0x0000_0080. LH 0x12 -> 0xFFFF_8081. LW 0x10 -> 0x8081_7F01.
  - Each rsp_valid comes 1 cycle after accept.
- Partial stores: SW 0x20 = 0xFFFF_FFFF, SB 0x22 = 0xAB, SH 0x20 = 0x1234 -> LW 0x20 = 0xFFAB_1234.
- Faults:
  - LH 0x21 -> rsp_err = 1, rdata = 0.
  - SW 0x22 with data 0 -> rsp_err = 1; a following LW 0x20 still returns 0xFFAB_1234.
  - funct3 = 011 -> rsp_err = 1.
  - With ADDR_W = 12, addr 0x1000 -> rsp_err = 1.
- WAIT_CYCLES = 3:
  - req_ready is low for exactly 4 cycles after accept; rsp_valid arrives 4 cycles after accept.
  - A req_valid held high during the wait is accepted on the first cycle back in IDLE.
- Reset during WAIT:
  - An SW 0x30 = 0x5555_AAAA is accepted and rst is pulsed 2 cycles later -> no rsp_valid for it, FSM returns to IDLE.
  - A following LW 0x30 returns 0x5555_AAAA.
